// File: rtl/mips_debug_pkg.sv
// Shared region, state and header definitions for the MIPS debug dump sequencer.
package mips_debug_pkg;

  typedef enum logic [1:0] {
    REGION_INSTR = 2'd0,
    REGION_REGS  = 2'd1,
    REGION_HILO  = 2'd2,
    REGION_MEM   = 2'd3
  } region_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_ADDR   = 3'd2,
    S_SAMPLE = 3'd3,
    S_SEND   = 3'd4,
    S_FINISH = 3'd5
  } dump_state_e;

  localparam logic [10:0] REGION_LEN_INSTR = 11'd256;
  localparam logic [10:0] REGION_LEN_REGS  = 11'd32;
  localparam logic [10:0] REGION_LEN_HILO  = 11'd2;
  localparam logic [10:0] REGION_LEN_MEM   = 11'd1024;

  localparam logic [7:0] DUMP_HEADER_BASE = 8'hA0;

  function automatic logic [9:0] region_last_addr(input logic [1:0] sel);
    logic [10:0] len;
    case (region_e'(sel))
      REGION_INSTR: len = REGION_LEN_INSTR;
      REGION_REGS:  len = REGION_LEN_REGS;
      REGION_HILO:  len = REGION_LEN_HILO;
      REGION_MEM:   len = REGION_LEN_MEM;
      default:      len = REGION_LEN_INSTR;
    endcase
    return 10'(len - 11'd1);
  endfunction

  function automatic logic [7:0] header_byte(input logic [1:0] sel);
    return DUMP_HEADER_BASE | {6'b000000, sel};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter with a valid/ready handshake; ready stays low
// from acceptance until the stop bit has fully elapsed.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_frame;

  // Frame shifter: bit 0 of r_frame is the line level, refilled with ones
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= 4'd0;
      r_frame <= 10'h3FF;
    end else if (!r_busy) begin
      if (valid) begin
        r_busy  <= 1'b1;
        r_cnt   <= '0;
        r_bit   <= 4'd0;
        r_frame <= {1'b1, data, 1'b0};
      end else begin
        r_frame <= 10'h3FF;
      end
    end else if (r_cnt == CNT_MAX) begin
      r_cnt <= '0;
      if (r_bit == 4'd9) begin
        r_busy  <= 1'b0;
        r_frame <= 10'h3FF;
      end else begin
        r_bit   <= r_bit + 4'd1;
        r_frame <= {1'b1, r_frame[9:1]};
      end
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign ready = ~r_busy;
  assign tx    = r_frame[0];

endmodule

// File: rtl/debug_dumper.sv
// Walks one region of the MIPS debug inspection port and streams a header
// byte plus every word (MSB byte first) over a UART line.
module debug_dumper
  import mips_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  dumpSelect,
  output logic [9:0]  derreference,
  output logic [1:0]  select,
  input  logic [31:0] word,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  dump_state_e r_state;
  logic [1:0]  r_sel;
  logic [9:0]  r_addr;
  logic [31:0] r_shift;
  logic [1:0]  r_byte;
  logic        r_busy;
  logic        r_done;

  logic        w_tx_valid;
  logic [7:0]  w_tx_data;
  logic        w_tx_ready;

  // Byte offered to the transmitter: header in HEADER, top of the shifter in SEND
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      S_HEADER: begin
        w_tx_valid = 1'b1;
        w_tx_data  = header_byte(r_sel);
      end
      S_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_shift[31:24];
      end
      default: begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
      end
    endcase
  end

  // Dump sequencer; the address only moves on the 4th byte handshake, so it
  // is steady from ADDR through SEND and never passes the region's last word
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_addr  <= 10'd0;
      r_shift <= 32'd0;
      r_byte  <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sel   <= dumpSelect;
            r_addr  <= 10'd0;
            r_busy  <= 1'b1;
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_tx_ready) begin
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_shift <= word;
          r_byte  <= 2'd0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (w_tx_ready) begin
            r_shift <= {r_shift[23:0], 8'h00};
            r_byte  <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              if (r_addr == region_last_addr(r_sel)) begin
                r_state <= S_FINISH;
              end else begin
                r_addr  <= r_addr + 10'd1;
                r_state <= S_ADDR;
              end
            end
          end
        end
        S_FINISH: begin
          if (w_tx_ready) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .reset (reset),
    .valid (w_tx_valid),
    .data  (w_tx_data),
    .ready (w_tx_ready),
    .tx    (tx)
  );

  assign derreference = r_addr;
  assign select       = r_sel;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_debug_dumper.sv
// Self-checking bench for debug_dumper: inspection-port model, UART receiver
// model and a byte scoreboard filled when each dump is started.
module tb_debug_dumper;

  localparam int CPB = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  dumpSelect;
  logic [9:0]  derreference;
  logic [1:0]  select;
  logic [31:0] word;
  logic        tx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [9:0] rx_addr_q[$];

  int         frame_errs = 0;
  int         done_cnt = 0;
  int         done_bad = 0;
  int         mon_bad = 0;
  logic [9:0] prev_addr = 10'd0;
  logic [9:0] peak_addr = 10'd0;

  debug_dumper #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dumpSelect   (dumpSelect),
    .derreference (derreference),
    .select       (select),
    .word         (word),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_word(input logic [1:0] sel, input logic [9:0] a);
    case (sel)
      2'd0:    return 32'hC0DE0000 | {22'd0, a};
      2'd1:    return {22'd0, a} * 32'h01010101;
      2'd2:    return (a == 10'd0) ? 32'h12345678 : 32'h9ABCDEF0;
      default: return ~{22'd0, a};
    endcase
  endfunction

  always_comb word = model_word(select, derreference);

  // UART receiver: start bit detected on a low sample, then one sample per bit
  initial begin : rx_model
    logic [7:0] b;
    logic [9:0] a;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        a = derreference;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) frame_errs = frame_errs + 1;
        rx_q.push_back(b);
        rx_addr_q.push_back(a);
      end
    end
  end

  // Address/done monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      if (busy !== 1'b0) done_bad <= done_bad + 1;
    end
    if (busy === 1'b1) begin
      if (derreference != prev_addr && derreference != prev_addr + 10'd1) mon_bad <= mon_bad + 1;
      if (derreference > peak_addr) peak_addr <= derreference;
      prev_addr <= derreference;
    end else begin
      prev_addr <= 10'd0;
      if (start === 1'b1) peak_addr <= 10'd0;
    end
  end

  task automatic push_expected(input logic [1:0] sel, input int len);
    logic [31:0] w;
    exp_q.push_back(8'hA0 | {6'd0, sel});
    for (int a = 0; a < len; a++) begin
      w = model_word(sel, 10'(a));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(negedge clk);
    dumpSelect = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int d0;
    d0 = done_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    dumpSelect = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (derreference !== 10'd0) begin errors++; $display("FAIL reset_addr got=%0d want=0", derreference); end
    checks++; if (select !== 2'd0) begin errors++; $display("FAIL reset_select got=%0d want=0", select); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hilo();
    bit to;
    bit seen_start;
    int d0;
    int n;
    d0 = done_cnt;
    push_expected(2'd2, 2);
    pulse_start(2'd2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hilo_start_busy got=%b want=1", busy); end
    seen_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (tx === 1'b0) seen_start = 1'b1;
      @(negedge clk);
    end
    checks++; if (!seen_start) begin errors++; $display("FAIL hilo_start_latency got=no_start_bit want=start_bit_within_3"); end
    wait_done(9 * (10 * CPB + 4) + 50, to);
    checks++; if (to) begin errors++; $display("FAIL hilo_done_timeout got=timeout want=done"); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL hilo_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL hilo_byte[%0d] got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL hilo_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hilo_busy_end got=%b want=0", busy); end
    checks++; if (done_bad != 0) begin errors++; $display("FAIL hilo_done_with_busy got=%0d want=0", done_bad); end
    exp_q.delete(); rx_q.delete(); rx_addr_q.delete();
  endtask

  task automatic test_regs();
    bit to;
    int n;
    int shown;
    int m0;
    m0 = mon_bad;
    push_expected(2'd1, 32);
    pulse_start(2'd1);
    wait_done(129 * (10 * CPB + 4) + 50, to);
    checks++; if (to) begin errors++; $display("FAIL regs_done_timeout got=timeout want=done"); end
    checks++; if (rx_q.size() != 129) begin errors++; $display("FAIL regs_count got=%0d want=129", rx_q.size()); end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    shown = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        if (shown < 8) $display("FAIL regs_byte[%0d] got=%h want=%h", i, rx_q[i], exp_q[i]);
        shown++;
      end
    end
    for (int k = 1; k < rx_addr_q.size(); k++) begin
      if ((k - 1) % 4 != 3) begin
        checks++;
        if (rx_addr_q[k] !== 10'((k - 1) / 4)) begin
          errors++;
          if (shown < 8) $display("FAIL regs_addr_stable[%0d] got=%0d want=%0d", k, rx_addr_q[k], (k - 1) / 4);
          shown++;
        end
      end
    end
    checks++; if (peak_addr !== 10'd31) begin errors++; $display("FAIL regs_peak_addr got=%0d want=31", peak_addr); end
    checks++; if (mon_bad != m0) begin errors++; $display("FAIL regs_addr_monotonic got=%0d want=0", mon_bad - m0); end
    exp_q.delete(); rx_q.delete(); rx_addr_q.delete();
  endtask

  task automatic test_busy_protect();
    bit to;
    int d0;
    int n;
    d0 = done_cnt;
    push_expected(2'd2, 2);
    pulse_start(2'd2);
    to = 1'b1;
    for (int i = 0; i < 9 * (10 * CPB + 4) + 50; i++) begin
      @(negedge clk);
      if (i == 60) begin dumpSelect = 2'd0; start = 1'b1; end
      if (i == 61) start = 1'b0;
      if (done_cnt != d0) begin to = 1'b0; break; end
    end
    repeat (40) @(negedge clk);
    checks++; if (to) begin errors++; $display("FAIL busy_done_timeout got=timeout want=done"); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL busy_count got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_byte[%0d] got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_pulses got=%0d want=1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle_after got=%b want=0", busy); end
    exp_q.delete(); rx_q.delete(); rx_addr_q.delete();
  endtask

  task automatic test_reset_mid_byte();
    bit to;
    pulse_start(2'd3);
    to = 1'b1;
    for (int i = 0; i < 60 * (10 * CPB + 4); i++) begin
      if (rx_q.size() >= 49) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++; if (to) begin errors++; $display("FAIL midrst_49_bytes got=%0d want=49", rx_q.size()); end
    to = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (tx === 1'b0) begin to = 1'b0; break; end
      @(negedge clk);
    end
    checks++; if (to) begin errors++; $display("FAIL midrst_byte50_start got=no_start want=start_bit"); end
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got=%b want=1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (derreference !== 10'd0) begin errors++; $display("FAIL midrst_addr got=%0d want=0", derreference); end
    @(negedge clk);
    reset = 1'b1;
    repeat (12 * CPB + 4) @(negedge clk);
    exp_q.delete(); rx_q.delete(); rx_addr_q.delete();
  endtask

  task automatic test_full_mem();
    bit to;
    int n;
    int shown;
    int m0;
    int fe0;
    m0 = mon_bad;
    fe0 = frame_errs;
    push_expected(2'd3, 1024);
    pulse_start(2'd3);
    wait_done(4097 * (10 * CPB + 4) + 100, to);
    checks++; if (to) begin errors++; $display("FAIL mem_done_timeout got=timeout want=done"); end
    checks++; if (rx_q.size() != 4097) begin errors++; $display("FAIL mem_count got=%0d want=4097", rx_q.size()); end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    shown = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        if (shown < 8) $display("FAIL mem_byte[%0d] got=%h want=%h", i, rx_q[i], exp_q[i]);
        shown++;
      end
    end
    if (rx_q.size() >= 5) begin
      checks++;
      if ({rx_q[rx_q.size()-4], rx_q[rx_q.size()-3], rx_q[rx_q.size()-2], rx_q[rx_q.size()-1]} !== 32'hFFFFFC00) begin
        errors++;
        $display("FAIL mem_last_word got=%h%h%h%h want=FFFFFC00", rx_q[rx_q.size()-4], rx_q[rx_q.size()-3], rx_q[rx_q.size()-2], rx_q[rx_q.size()-1]);
      end
    end else begin
      checks++; errors++; $display("FAIL mem_last_word got=%0d_bytes want=FFFFFC00", rx_q.size());
    end
    checks++; if (peak_addr !== 10'd1023) begin errors++; $display("FAIL mem_peak_addr got=%0d want=1023", peak_addr); end
    checks++; if (mon_bad != m0) begin errors++; $display("FAIL mem_addr_wrap got=%0d want=0", mon_bad - m0); end
    checks++; if (frame_errs != fe0) begin errors++; $display("FAIL mem_framing got=%0d want=0", frame_errs - fe0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mem_busy_end got=%b want=0", busy); end
    exp_q.delete(); rx_q.delete(); rx_addr_q.delete();
  endtask

  initial begin
    test_reset();
    test_hilo();
    test_regs();
    test_busy_protect();
    test_reset_mid_byte();
    test_full_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
